mem_port_arbiter: RTL and testbench

- Shares the single-ported valid/ready memory (cache) between two requesters: port 0 (instruction fetch) and port 1 (load/store).
- Arbitrates each cycle with round-robin priority and forwards the winner's request downstream.
- Records the winning port in an in-order owner FIFO, then steers each returning response to its owner.
- Sits between the pipeline stages and the memory module; only this block drives the memory's request and response handshakes.

---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single valid/ready memory port.
// An in-order owner FIFO remembers who issued each request so responses go back to the right port.
module mem_port_arbiter #(
  parameter int OWN_DEPTH = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  localparam int PW       = (OWN_DEPTH > 1) ? $clog2(OWN_DEPTH) : 1,
  localparam int CW       = PW + 1
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          p0_req_valid,
  output logic          p0_req_ready,
  input  logic [AW-1:0] p0_req_addr,
  input  logic          p0_req_op,
  input  logic [DW-1:0] p0_req_wdata,
  output logic          p0_resp_valid,
  input  logic          p0_resp_ready,
  output logic [DW-1:0] p0_resp_data,

  input  logic          p1_req_valid,
  output logic          p1_req_ready,
  input  logic [AW-1:0] p1_req_addr,
  input  logic          p1_req_op,
  input  logic [DW-1:0] p1_req_wdata,
  output logic          p1_resp_valid,
  input  logic          p1_resp_ready,
  output logic [DW-1:0] p1_resp_data,

  output logic          m_req_valid,
  input  logic          m_req_ready,
  output logic [AW-1:0] m_req_addr,
  output logic          m_req_op,
  output logic [DW-1:0] m_req_wdata,
  input  logic          m_resp_valid,
  output logic          m_resp_ready,
  input  logic [DW-1:0] m_resp_data,

  output logic [CW-1:0] outstanding,
  output logic          orphan_err
);

  logic [OWN_DEPTH-1:0] own_q, own_d;
  logic [PW-1:0]        head_q, head_d;
  logic [PW-1:0]        tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 prio_q, prio_d;
  logic                 orphan_err_q, orphan_err_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic                 op_q, op_d;
  logic [DW-1:0]        wdata_q, wdata_d;

  logic fifo_empty;
  logic fifo_full;
  logic head_port;
  logic pop;
  logic push;
  logic can_issue;
  logic grant_any;
  logic grant_port;

  always_comb begin
    fifo_empty    = (count_q == '0);
    fifo_full     = (count_q == CW'(OWN_DEPTH));
    head_port     = own_q[head_q];

    p0_resp_valid = 1'b0;
    p1_resp_valid = 1'b0;
    m_resp_ready  = 1'b0;
    p0_resp_data  = m_resp_data;
    p1_resp_data  = m_resp_data;
    if (!reset) begin
      // With nobody owed a response, drain it so the memory never wedges.
      if (fifo_empty) begin
        m_resp_ready = 1'b1;
      end else if (head_port) begin
        p1_resp_valid = m_resp_valid;
        m_resp_ready  = p1_resp_ready;
      end else begin
        p0_resp_valid = m_resp_valid;
        m_resp_ready  = p0_resp_ready;
      end
    end

    pop        = !fifo_empty && m_resp_valid && m_resp_ready;
    can_issue  = !fifo_full || pop;
    grant_any  = !reset && can_issue && (p0_req_valid || p1_req_valid);
    grant_port = (p0_req_valid && p1_req_valid) ? prio_q : p1_req_valid;
    push       = grant_any && m_req_ready;

    m_req_valid  = grant_any;
    p0_req_ready = push && !grant_port;
    p1_req_ready = push && grant_port;

    addr_d  = addr_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    if (grant_any) begin
      addr_d  = grant_port ? p1_req_addr  : p0_req_addr;
      op_d    = grant_port ? p1_req_op    : p0_req_op;
      wdata_d = grant_port ? p1_req_wdata : p0_req_wdata;
    end
    m_req_addr  = addr_d;
    m_req_op    = op_d;
    m_req_wdata = wdata_d;

    own_d = own_q;
    if (push) begin
      own_d[tail_q] = grant_port;
    end
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    head_d  = pop  ? head_q + PW'(1) : head_q;
    count_d = count_q + CW'(push) - CW'(pop);

    prio_d       = push ? !grant_port : prio_q;
    orphan_err_d = orphan_err_q || (!reset && fifo_empty && m_resp_valid);

    outstanding = count_q;
    orphan_err  = orphan_err_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      own_q        <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      prio_q       <= 1'b0;
      orphan_err_q <= 1'b0;
      addr_q       <= '0;
      op_q         <= 1'b0;
      wdata_q      <= '0;
    end else begin
      own_q        <= own_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      prio_q       <= prio_d;
      orphan_err_q <= orphan_err_d;
      addr_q       <= addr_d;
      op_q         <= op_d;
      wdata_q      <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a behavioural memory and two requesters feed the DUT,
// a scoreboard tracks per-port expected responses and the in-order ownership of the memory.
module tb_mem_port_arbiter;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic        op;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req_valid, p0_req_ready, p0_req_op, p0_resp_valid, p0_resp_ready;
  logic [31:0] p0_req_addr, p0_req_wdata, p0_resp_data;
  logic        p1_req_valid, p1_req_ready, p1_req_op, p1_resp_valid, p1_resp_ready;
  logic [31:0] p1_req_addr, p1_req_wdata, p1_resp_data;
  logic        m_req_valid, m_req_ready, m_req_op, m_resp_valid, m_resp_ready;
  logic [31:0] m_req_addr, m_req_wdata, m_resp_data;
  logic [1:0]  outstanding;
  logic        orphan_err;

  mem_port_arbiter #(.OWN_DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_addr(p0_req_addr),
    .p0_req_op(p0_req_op), .p0_req_wdata(p0_req_wdata), .p0_resp_valid(p0_resp_valid),
    .p0_resp_ready(p0_resp_ready), .p0_resp_data(p0_resp_data),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_addr(p1_req_addr),
    .p1_req_op(p1_req_op), .p1_req_wdata(p1_req_wdata), .p1_resp_valid(p1_resp_valid),
    .p1_resp_ready(p1_resp_ready), .p1_resp_data(p1_resp_data),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_op(m_req_op), .m_req_wdata(m_req_wdata), .m_resp_valid(m_resp_valid),
    .m_resp_ready(m_resp_ready), .m_resp_data(m_resp_data),
    .outstanding(outstanding), .orphan_err(orphan_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int n_resp   = 0;

  // Reference state: who is owed the next memory response, what each port expects, memory contents.
  bit          own_order[$];
  exp_t        exp_q[2][$];
  logic [31:0] mem_pend[$];
  logic [31:0] ref_mem[logic [31:0]];
  bit          model_prio;
  bit          model_orphan;
  bit          pop_now;
  bit          resp_taken;
  bit          acc[2];

  bit          cur_v[2];
  logic [31:0] cur_addr[2];
  logic        cur_op[2];
  logic [31:0] cur_wd[2];
  int          req_rate, mrdy_rate, rsp_rate, rrdy_rate;
  bit          inject_orphan;
  bit          rst_req;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic drive_cycle();
    @(posedge clk);
    #1;
    reset = rst_req;
    for (int p = 0; p < 2; p++) begin
      if (acc[p] || reset) cur_v[p] = 1'b0;
      if (!cur_v[p] && !reset && ($urandom_range(0, 99) < req_rate)) begin
        cur_v[p]    = 1'b1;
        cur_addr[p] = 32'h100 + ($urandom_range(0, 7) << 2);
        cur_op[p]   = 1'($urandom_range(0, 1));
        cur_wd[p]   = $urandom;
      end
    end
    p0_req_valid = cur_v[0];
    p0_req_addr  = cur_addr[0];
    p0_req_op    = cur_op[0];
    p0_req_wdata = cur_wd[0];
    p1_req_valid = cur_v[1];
    p1_req_addr  = cur_addr[1];
    p1_req_op    = cur_op[1];
    p1_req_wdata = cur_wd[1];
    m_req_ready   = ($urandom_range(0, 99) < mrdy_rate);
    p0_resp_ready = ($urandom_range(0, 99) < rrdy_rate);
    p1_resp_ready = ($urandom_range(0, 99) < rrdy_rate);
    if (reset) begin
      m_resp_valid = 1'b0;
    end else if (inject_orphan) begin
      m_resp_valid = 1'b1;
      m_resp_data  = $urandom;
    end else if (m_resp_valid && !resp_taken && mem_pend.size() > 0) begin
      m_resp_valid = 1'b1;
    end else if (mem_pend.size() > 0 && ($urandom_range(0, 99) < rsp_rate)) begin
      m_resp_valid = 1'b1;
      m_resp_data  = mem_pend[0];
    end else begin
      m_resp_valid = 1'b0;
    end
  endtask

  // Response-side monitor: routing, occupancy, orphan flag and response data.
  always @(negedge clk) begin
    bit   h;
    logic rdy;
    exp_t e;
    pop_now    = 1'b0;
    resp_taken = 1'b0;
    if (reset) begin
      chk("reset_outputs", {m_req_valid, p0_req_ready, p1_req_ready,
                            p0_resp_valid, p1_resp_valid, m_resp_ready}, 0);
      model_orphan = 1'b0;
    end else begin
      chk("outstanding", outstanding, own_order.size());
      chk("orphan_err", orphan_err, model_orphan);
      if (m_resp_valid) begin
        if (own_order.size() == 0) begin
          chk("orphan_drain", {p0_resp_valid, p1_resp_valid, m_resp_ready}, 3'b001);
          model_orphan = 1'b1;
          resp_taken   = m_resp_ready;
        end else begin
          h   = own_order[0];
          rdy = h ? p1_resp_ready : p0_resp_ready;
          chk("resp_route", {p0_resp_valid, p1_resp_valid, m_resp_ready}, {!h, h, rdy});
        end
      end else begin
        chk("resp_idle", {p0_resp_valid, p1_resp_valid}, 0);
      end
      for (int p = 0; p < 2; p++) begin
        if ((p == 0) ? (p0_resp_valid && p0_resp_ready) : (p1_resp_valid && p1_resp_ready)) begin
          if (exp_q[p].size() == 0) begin
            chk($sformatf("unexpected_resp_p%0d", p), 1, 0);
          end else begin
            e = exp_q[p].pop_front();
            n_resp++;
            if (!e.op) chk($sformatf("rdata_p%0d", p), (p == 0) ? p0_resp_data : p1_resp_data, e.data);
          end
        end
      end
      if (m_resp_valid && m_resp_ready && own_order.size() > 0) begin
        void'(own_order.pop_front());
        if (mem_pend.size() > 0) void'(mem_pend.pop_front());
        pop_now    = 1'b1;
        resp_taken = 1'b1;
      end
    end
  end

  // Request-side scoring: round-robin grant, stall on full tracking, request muxing.
  always begin
    bit   v0, v1, exp_gnt, exp_port, fired, fp;
    int   sz;
    logic [31:0] d;
    @(negedge clk);
    #4;
    acc[0] = 1'b0;
    acc[1] = 1'b0;
    if (reset) begin
      own_order.delete();
      exp_q[0].delete();
      exp_q[1].delete();
      mem_pend.delete();
      model_prio = 1'b0;
    end else begin
      v0       = p0_req_valid;
      v1       = p1_req_valid;
      sz       = own_order.size() + (pop_now ? 1 : 0);
      exp_gnt  = (v0 || v1) && ((sz < DEPTH) || pop_now);
      exp_port = (v0 && v1) ? model_prio : v1;
      chk("m_req_valid", m_req_valid, exp_gnt);
      chk("req_ready", {p0_req_ready, p1_req_ready},
          {exp_gnt && !exp_port && m_req_ready, exp_gnt && exp_port && m_req_ready});
      if (exp_gnt)
        chk("m_req_fields", {m_req_addr, m_req_op, m_req_wdata},
            {cur_addr[exp_port], cur_op[exp_port], cur_wd[exp_port]});
      chk("m_req_known", $isunknown({m_req_addr, m_req_op, m_req_wdata}), 0);
      fired = 1'b0;
      fp    = 1'b0;
      if (v0 && p0_req_ready) begin
        fired = 1'b1;
        fp    = 1'b0;
      end else if (v1 && p1_req_ready) begin
        fired = 1'b1;
        fp    = 1'b1;
      end
      if (fired) begin
        if (cur_op[fp]) begin
          ref_mem[cur_addr[fp]] = cur_wd[fp];
          d = $urandom;
        end else begin
          d = mem_read(cur_addr[fp]);
        end
        own_order.push_back(fp);
        exp_q[fp].push_back('{op: cur_op[fp], data: d});
        mem_pend.push_back(d);
        model_prio = !fp;
        acc[fp]    = 1'b1;
      end
    end
  end

  initial begin
    int budget;
    reset = 1'b1;
    {p0_req_valid, p0_req_op, p0_resp_ready, p1_req_valid, p1_req_op, p1_resp_ready} = '0;
    {p0_req_addr, p0_req_wdata, p1_req_addr, p1_req_wdata} = '0;
    {m_req_ready, m_resp_valid} = '0;
    m_resp_data = '0;
    rst_req = 1'b1;
    inject_orphan = 1'b0;
    req_rate = 0; mrdy_rate = 0; rsp_rate = 0; rrdy_rate = 0;
    repeat (3) drive_cycle();
    rst_req = 1'b0;

    req_rate = 40; mrdy_rate = 70; rsp_rate = 60; rrdy_rate = 80;
    repeat (400) drive_cycle();

    req_rate = 100; mrdy_rate = 100; rsp_rate = 100; rrdy_rate = 100;
    repeat (40) drive_cycle();

    rsp_rate = 0;
    repeat (20) drive_cycle();
    rsp_rate = 100;
    repeat (20) drive_cycle();

    req_rate = 60; mrdy_rate = 60; rsp_rate = 80; rrdy_rate = 30;
    repeat (200) drive_cycle();

    req_rate = 100; mrdy_rate = 100; rsp_rate = 0; rrdy_rate = 100;
    budget = 0;
    while (own_order.size() != DEPTH && budget < 30) begin
      drive_cycle();
      budget++;
    end
    chk("fill_before_reset", own_order.size(), DEPTH);
    rst_req = 1'b1;
    drive_cycle();
    rst_req = 1'b0;
    req_rate = 0;
    inject_orphan = 1'b1;
    repeat (2) drive_cycle();
    inject_orphan = 1'b0;
    repeat (10) drive_cycle();
    chk("orphan_sticky", model_orphan, 1);
    rst_req = 1'b1;
    drive_cycle();
    rst_req = 1'b0;
    repeat (3) drive_cycle();

    @(posedge clk);
    chk("responses_seen", (n_resp > 50), 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
